// File: rtl/xlr8_hub75_bcm_driver_if.sv
// rtl/xlr8_hub75_bcm_driver_if.sv - AVR data-memory bus bundle for the HUB75 driver XB
interface xlr8_hub75_bcm_driver_if;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic [7:0] ramadr;
  logic       io_out_en;
  logic       ramre;
  logic       ramwe;
  logic       dm_sel;

  modport master (
    output dbus_in, ramadr, ramre, ramwe, dm_sel,
    input  dbus_out, io_out_en
  );

  modport slave (
    input  dbus_in, ramadr, ramre, ramwe, dm_sel,
    output dbus_out, io_out_en
  );
endinterface

// File: rtl/xlr8_hub75_bcm_driver.sv
// rtl/xlr8_hub75_bcm_driver.sv - HUB75 panel driver with dual-port frame buffer and BCM scan engine
module xlr8_hub75_bcm_driver #(
  parameter int CTRL_ADDR     = 0,
  parameter int COLS          = 32,
  parameter int ROW_ADDR_BITS = 4,
  parameter int BCM_BITS      = 4,
  parameter int CLK_DIV       = 2,
  parameter int BASE_TIME     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  xlr8_hub75_bcm_driver_if.slave   dm,
  output logic                     clk_out,
  output logic                     r1,
  output logic                     g1,
  output logic                     b1,
  output logic                     r2,
  output logic                     g2,
  output logic                     b2,
  output logic [ROW_ADDR_BITS-1:0] row_sel,
  output logic                     latch_SR,
  output logic                     oe
);

  localparam int unsigned ROWS = 1 << ROW_ADDR_BITS;
  localparam int unsigned HALF = COLS * ROWS;
  localparam int unsigned N    = 2 * HALF;
  localparam int AW = $clog2(N);
  localparam int HW = $clog2(HALF);
  localparam int CW = $clog2(COLS);
  localparam int PW = (BCM_BITS > 1) ? $clog2(BCM_BITS) : 1;
  localparam int WW = 3 * BCM_BITS;
  localparam int IW = $clog2(WW);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SHIFT_LO, S_SHIFT_HI, S_BLANK, S_LATCH, S_DISPLAY
  } state_t;

  state_t                   state;
  logic                     enable;
  logic                     frame_tgl;
  logic [AW-1:0]            ptr;
  logic [BCM_BITS-1:0]      red_stage;
  logic [BCM_BITS-1:0]      grn_stage;

  logic hit_ctrl, hit_addr_l, hit_addr_h, hit_red, hit_grn, hit_blu;
  assign hit_ctrl   = dm.dm_sel && (dm.ramadr == 8'(CTRL_ADDR + 0));
  assign hit_addr_l = dm.dm_sel && (dm.ramadr == 8'(CTRL_ADDR + 1));
  assign hit_addr_h = dm.dm_sel && (dm.ramadr == 8'(CTRL_ADDR + 2));
  assign hit_red    = dm.dm_sel && (dm.ramadr == 8'(CTRL_ADDR + 3));
  assign hit_grn    = dm.dm_sel && (dm.ramadr == 8'(CTRL_ADDR + 4));
  assign hit_blu    = dm.dm_sel && (dm.ramadr == 8'(CTRL_ADDR + 5));

  // Pointer viewed as a 16-bit register pair; bits above AW are dropped on write
  logic [15:0]   ptr_ext, ptr_wr_l, ptr_wr_h;
  logic [AW-1:0] ptr_inc;
  assign ptr_ext  = 16'(ptr);
  assign ptr_wr_l = {ptr_ext[15:8], dm.dbus_in};
  assign ptr_wr_h = {dm.dbus_in, ptr_ext[7:0]};
  assign ptr_inc  = (32'(ptr) == N - 1) ? '0 : ptr + AW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable    <= 1'b0;
      ptr       <= '0;
      red_stage <= '0;
      grn_stage <= '0;
    end else if (dm.ramwe) begin
      if (hit_ctrl)   enable    <= dm.dbus_in[0];
      if (hit_addr_l) ptr       <= ptr_wr_l[AW-1:0];
      if (hit_addr_h) ptr       <= ptr_wr_h[AW-1:0];
      if (hit_red)    red_stage <= dm.dbus_in[BCM_BITS-1:0];
      if (hit_grn)    grn_stage <= dm.dbus_in[BCM_BITS-1:0];
      if (hit_blu)    ptr       <= ptr_inc;
    end
  end

  // Frame buffer split by panel half so one fetch reads both halves of a column
  logic [WW-1:0] mem_top [0:HALF-1];
  logic [WW-1:0] mem_bot [0:HALF-1];
  logic [31:0]   ptr32;
  logic          wr_bot;
  logic [HW-1:0] wr_idx;
  logic [WW-1:0] wr_word;
  assign ptr32   = 32'(ptr);
  assign wr_bot  = (ptr32 >= HALF);
  assign wr_idx  = HW'(wr_bot ? ptr32 - HALF : ptr32);
  assign wr_word = {red_stage, grn_stage, dm.dbus_in[BCM_BITS-1:0]};

  always_ff @(posedge clk) begin
    if (dm.ramwe && hit_blu) begin
      if (wr_bot) mem_bot[wr_idx] <= wr_word;
      else        mem_top[wr_idx] <= wr_word;
    end
  end

  logic [7:0] ctrl_rd;
  assign ctrl_rd      = {frame_tgl, state != S_IDLE, 5'b0, enable};
  assign dm.io_out_en = dm.ramre && (hit_ctrl || hit_addr_l || hit_addr_h);

  always_comb begin
    dm.dbus_out = '0;
    if (dm.io_out_en) begin
      if (hit_ctrl)   dm.dbus_out = ctrl_rd;
      if (hit_addr_l) dm.dbus_out = ptr_ext[7:0];
      if (hit_addr_h) dm.dbus_out = ptr_ext[15:8];
    end
  end

  logic [ROW_ADDR_BITS-1:0] row;
  logic [PW-1:0]            plane;
  logic [CW-1:0]            col;
  logic [31:0]              cnt;
  logic                     oe_q;

  logic [HW-1:0] fetch_idx;
  logic [WW-1:0] top_word, bot_word;
  logic [IW-1:0] idx_r, idx_g, idx_b;
  logic          last_col, last_plane, last_row;
  logic [31:0]   disp_last;
  assign fetch_idx  = HW'(32'(row) * COLS + 32'(col));
  assign top_word   = mem_top[fetch_idx];
  assign bot_word   = mem_bot[fetch_idx];
  assign idx_b      = IW'(plane);
  assign idx_g      = IW'(BCM_BITS) + IW'(plane);
  assign idx_r      = IW'(2 * BCM_BITS) + IW'(plane);
  assign last_col   = (col == CW'(COLS - 1));
  assign last_plane = (plane == PW'(BCM_BITS - 1));
  assign last_row   = (row == {ROW_ADDR_BITS{1'b1}});
  assign disp_last  = (32'(BASE_TIME) << plane) - 32'd1;

  // Dropping enable blanks the panel immediately, ahead of the FSM reaching IDLE
  assign oe = oe_q | ~enable;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      row       <= '0;
      plane     <= '0;
      col       <= '0;
      cnt       <= '0;
      clk_out   <= 1'b0;
      {r1, g1, b1, r2, g2, b2} <= '0;
      row_sel   <= '0;
      latch_SR  <= 1'b0;
      oe_q      <= 1'b1;
      frame_tgl <= 1'b0;
    end else if (!enable) begin
      state     <= S_IDLE;
      row       <= '0;
      plane     <= '0;
      col       <= '0;
      cnt       <= '0;
      clk_out   <= 1'b0;
      {r1, g1, b1, r2, g2, b2} <= '0;
      row_sel   <= '0;
      latch_SR  <= 1'b0;
      oe_q      <= 1'b1;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          {r1, g1, b1} <= {top_word[idx_r], top_word[idx_g], top_word[idx_b]};
          {r2, g2, b2} <= {bot_word[idx_r], bot_word[idx_g], bot_word[idx_b]};
          cnt   <= '0;
          state <= S_SHIFT_LO;
        end
        S_SHIFT_LO: begin
          if (cnt == 32'(CLK_DIV - 1)) begin
            cnt     <= '0;
            clk_out <= 1'b1;
            state   <= S_SHIFT_HI;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_SHIFT_HI: begin
          if (cnt == 32'(CLK_DIV - 1)) begin
            cnt     <= '0;
            clk_out <= 1'b0;
            if (last_col) begin
              col     <= '0;
              row_sel <= row;
              {r1, g1, b1, r2, g2, b2} <= '0;
              state   <= S_BLANK;
            end else begin
              col   <= col + CW'(1);
              state <= S_FETCH;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_BLANK: begin
          latch_SR <= 1'b1;
          state    <= S_LATCH;
        end
        S_LATCH: begin
          latch_SR <= 1'b0;
          oe_q     <= 1'b0;
          cnt      <= '0;
          state    <= S_DISPLAY;
        end
        S_DISPLAY: begin
          if (cnt == disp_last) begin
            cnt   <= '0;
            oe_q  <= 1'b1;
            state <= S_FETCH;
            if (last_plane) begin
              plane <= '0;
              row   <= row + ROW_ADDR_BITS'(1);
              if (last_row) frame_tgl <= ~frame_tgl;
            end else begin
              plane <= plane + PW'(1);
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xlr8_hub75_bcm_driver.sv
// tb/tb_xlr8_hub75_bcm_driver.sv - table-driven and sequence checks for the HUB75 BCM driver
module tb_xlr8_hub75_bcm_driver;
  localparam int HIST = 171;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  xlr8_hub75_bcm_driver_if bus();

  logic       clk_out, r1, g1, b1, r2, g2, b2, latch_SR, oe;
  logic [0:0] row_sel;
  logic [5:0] rgb;
  assign rgb = {r1, g1, b1, r2, g2, b2};

  xlr8_hub75_bcm_driver #(
    .CTRL_ADDR(8'h40), .COLS(4), .ROW_ADDR_BITS(1),
    .BCM_BITS(2), .CLK_DIV(1), .BASE_TIME(4)
  ) dut (
    .clk(clk), .rst(rst), .dm(bus),
    .clk_out(clk_out), .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .row_sel(row_sel), .latch_SR(latch_SR), .oe(oe)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit         we;
    bit         sel;
    logic [7:0] addr;
    logic [7:0] data;
    logic       exp_en;
    logic [7:0] exp_d;
    string      name;
  } vec_t;

  vec_t vecs[$];

  logic [5:0] rgb_h  [HIST];
  logic [7:0] ctrl_h [HIST];
  logic       clk_h  [HIST];
  logic       oe_h   [HIST];
  logic       lat_h  [HIST];
  logic       rs_h   [HIST];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, input bit sel = 1'b1);
    bus.dm_sel  = sel;
    bus.ramadr  = a;
    bus.dbus_in = d;
    bus.ramwe   = 1'b1;
    @(posedge clk);
    #1;
    bus.ramwe  = 1'b0;
    bus.dm_sel = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input bit sel, output logic [7:0] d, output logic en);
    bus.dm_sel = sel;
    bus.ramadr = a;
    bus.ramre  = 1'b1;
    #1;
    d = bus.dbus_out;
    en = bus.io_out_en;
    bus.ramre  = 1'b0;
    bus.dm_sel = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       en;
    int         cnt;

    bus.dbus_in = '0;
    bus.ramadr  = '0;
    bus.ramre   = 1'b0;
    bus.ramwe   = 1'b0;
    bus.dm_sel  = 1'b0;

    // Register access vectors: reads are checked, writes only set up state
    vecs.push_back('{0, 1, 8'h40, 8'h00, 1'b1, 8'h00, "ctrl_after_reset"});
    vecs.push_back('{1, 1, 8'h41, 8'hFF, 1'b0, 8'h00, ""});
    vecs.push_back('{0, 1, 8'h41, 8'h00, 1'b1, 8'h0F, "addr_l_truncated"});
    vecs.push_back('{1, 1, 8'h42, 8'hFF, 1'b0, 8'h00, ""});
    vecs.push_back('{0, 1, 8'h42, 8'h00, 1'b1, 8'h00, "addr_h_reads_zero"});
    vecs.push_back('{0, 1, 8'h41, 8'h00, 1'b1, 8'h0F, "addr_l_kept_by_h_write"});
    vecs.push_back('{1, 1, 8'h43, 8'h00, 1'b0, 8'h00, ""});
    vecs.push_back('{1, 1, 8'h44, 8'h00, 1'b0, 8'h00, ""});
    vecs.push_back('{1, 1, 8'h45, 8'h01, 1'b0, 8'h00, ""});
    vecs.push_back('{0, 1, 8'h41, 8'h00, 1'b1, 8'h00, "ptr_wrap"});
    vecs.push_back('{0, 1, 8'h43, 8'h00, 1'b0, 8'h00, "read_red"});
    vecs.push_back('{0, 1, 8'h44, 8'h00, 1'b0, 8'h00, "read_grn"});
    vecs.push_back('{0, 1, 8'h45, 8'h00, 1'b0, 8'h00, "read_blu"});
    vecs.push_back('{0, 1, 8'h46, 8'h00, 1'b0, 8'h00, "read_0x46"});
    vecs.push_back('{0, 0, 8'h40, 8'h00, 1'b0, 8'h00, "read_unselected"});
    vecs.push_back('{1, 1, 8'h41, 8'h05, 1'b0, 8'h00, ""});
    vecs.push_back('{1, 0, 8'h41, 8'h09, 1'b0, 8'h00, ""});
    vecs.push_back('{0, 1, 8'h41, 8'h00, 1'b1, 8'h05, "write_needs_dm_sel"});
    vecs.push_back('{1, 1, 8'h40, 8'hFE, 1'b0, 8'h00, ""});
    vecs.push_back('{0, 1, 8'h40, 8'h00, 1'b1, 8'h00, "ctrl_only_bit0"});

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_held", {clk_out, rgb, row_sel, latch_SR, oe, bus.io_out_en}, 11'b0_000000_0_0_1_0);
    rst = 1'b0;
    step(1);
    check("reset_outputs_released", {clk_out, rgb, row_sel, latch_SR, oe}, 10'b0_000000_0_0_1);

    foreach (vecs[i]) begin
      if (vecs[i].we) begin
        wr(vecs[i].addr, vecs[i].data, vecs[i].sel);
      end else begin
        rd(vecs[i].addr, vecs[i].sel, d, en);
        check({vecs[i].name, "_en"}, en, vecs[i].exp_en);
        check({vecs[i].name, "_data"}, d, vecs[i].exp_d);
        step(1);
      end
    end

    // Pixels 0..14: pixel 0 = R3 G0 B1, pixel 8 = R2; pixel 15 keeps B1 from the wrap test
    wr(8'h41, 8'h00);
    wr(8'h42, 8'h00);
    for (int i = 0; i < 15; i++) begin
      wr(8'h43, (i == 0) ? 8'd3 : (i == 8) ? 8'd2 : 8'd0);
      wr(8'h44, 8'd0);
      wr(8'h45, (i == 0) ? 8'd1 : 8'd0);
    end
    rd(8'h41, 1'b1, d, en);
    check("ptr_after_load", d, 8'h0F);

    // Enable at edge t, then record outputs for k = 1..170 cycles after it
    wr(8'h40, 8'h01);
    for (int k = 0; k < HIST; k++) begin
      if (k > 0) step(1);
      rgb_h[k] = rgb;
      clk_h[k] = clk_out;
      oe_h[k]  = oe;
      lat_h[k] = latch_SR;
      rs_h[k]  = row_sel[0];
      rd(8'h40, 1'b1, d, en);
      ctrl_h[k] = d;
    end

    check("ctrl_idle_at_enable_edge", ctrl_h[0], 8'h01);
    check("ctrl_scanning", ctrl_h[1], 8'h41);
    check("fetch_clk_out", clk_h[1], 1'b0);
    cnt = 0;
    for (int k = HIST - 1; k >= 1; k--) if (clk_h[k]) cnt = k;
    check("first_clk_out_rise", cnt, 3);
    check("plane0_col0_rgb", rgb_h[2], 6'b101_000);
    check("plane1_col0_rgb", rgb_h[20], 6'b100_100);
    check("row1_col3_b2", rgb_h[51], 6'b000_001);
    check("frame2_plane0_rgb", rgb_h[82], 6'b101_000);

    cnt = 0;
    for (int k = 1; k <= 18; k++) if (clk_h[k] && !clk_h[k-1]) cnt++;
    check("plane0_clk_pulses", cnt, 4);
    cnt = 0;
    for (int k = 19; k <= 40; k++) if (clk_h[k] && !clk_h[k-1]) cnt++;
    check("plane1_clk_pulses", cnt, 4);
    cnt = 0;
    for (int k = 1; k <= 18; k++) if (lat_h[k]) cnt++;
    check("plane0_latch_pulses", cnt, 1);
    check("latch_cycle", {lat_h[13], lat_h[14], lat_h[15]}, 3'b010);
    cnt = 0;
    for (int k = 1; k <= 18; k++) if (!oe_h[k]) cnt++;
    check("plane0_oe_low", cnt, 4);
    cnt = 0;
    for (int k = 19; k <= 40; k++) if (!oe_h[k]) cnt++;
    check("plane1_oe_low", cnt, 8);
    check("oe_low_starts_after_latch", {oe_h[14], oe_h[15], oe_h[18], oe_h[19]}, 4'b1001);
    cnt = 0;
    for (int k = 1; k <= 40; k++) if (rs_h[k]) cnt++;
    check("row0_row_sel", cnt, 0);
    check("row_sel_changes_in_blank", {rs_h[52], rs_h[53]}, 2'b01);
    check("row_sel_wrap", {rs_h[92], rs_h[93]}, 2'b10);
    cnt = 0;
    for (int k = 1; k < HIST; k++) if (rs_h[k] != rs_h[k-1] && !oe_h[k]) cnt++;
    check("row_sel_change_with_oe_low", cnt, 0);
    check("frame_tgl_before_80", ctrl_h[80][7], 1'b0);
    check("frame_tgl_at_81", ctrl_h[81][7], 1'b1);
    check("frame_tgl_at_160", ctrl_h[160][7], 1'b1);
    check("frame_tgl_at_161", ctrl_h[161][7], 1'b0);

    // Mid-row disable during SHIFT_HI of col 2, then restart from row 0 col 0
    wr(8'h40, 8'h00);
    step(2);
    rd(8'h40, 1'b1, d, en);
    check("idle_after_disable", d, 8'h00);
    wr(8'h40, 8'h01);
    step(8);
    wr(8'h40, 8'h00);
    check("disable_in_shift_hi", {clk_out, oe}, 2'b11);
    step(1);
    check("disable_clk_out_low", {clk_out, rgb}, 7'b0);
    rd(8'h40, 1'b1, d, en);
    check("disable_idle", d, 8'h00);
    wr(8'h40, 8'h01);
    step(1);
    check("reenable_fetch_clk", clk_out, 1'b0);
    step(1);
    check("reenable_data", {clk_out, rgb}, 7'b0_101_000);
    step(1);
    check("reenable_first_rise", clk_out, 1'b1);

    // Clearing enable in DISPLAY must raise oe before the FSM leaves
    step(12);
    check("display_oe_low", oe, 1'b0);
    wr(8'h40, 8'h00);
    check("oe_forced_high", oe, 1'b1);
    rd(8'h40, 1'b1, d, en);
    check("fsm_still_scanning", d, 8'h40);
    step(1);
    rd(8'h40, 1'b1, d, en);
    check("idle_after_display_disable", d, 8'h00);

    // Asynchronous reset mid-DISPLAY of row 1
    wr(8'h40, 8'h01);
    step(56);
    check("pre_reset_display_row1", {oe, row_sel}, 2'b01);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {clk_out, rgb, row_sel, latch_SR, oe}, 10'b0_000000_0_0_1);
    rd(8'h40, 1'b1, d, en);
    check("reset_ctrl_read", {en, d}, 9'h100);
    rd(8'h41, 1'b1, d, en);
    check("reset_ptr_read", {en, d}, 9'h100);
    step(1);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
